i2c_bus_monitor: RTL and testbench
==================================

I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

Interface
REQ-001 Parameters; each SHALL be declared as name, default, meaning:
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- FILTER_LEN, 4, consecutive stable cycles required to accept a line change (1..15).
- STRETCH_MIN, 8, consecutive cycles that qualify as SCL stretch (1..255).
REQ-002 Ports SHALL be exactly as follows (name, direction, width, meaning):
- i2c_core_clock_i  in  1  core clock.
- reset_bit_i  in  1  reset.
- scl_i  in  1  raw SCL bus level.
- sda_i  in  1  raw SDA bus level.
- master_scl_oe_i  in  1  master drives SCL.
- master_scl_i  in  1  SCL value the master drives.
- master_sda_oe_i  in  1  master drives SDA.
- master_sda_i  in  1  SDA value the master drives.
- arb_clr_i  in  1  clears arb_lost_o.
- scl_o  out  1  filtered SCL.
- sda_o  out  1  filtered SDA.
- scl_rise_o  out  1  one-cycle pulse on filtered SCL rising edge.
- scl_fall_o  out  1  one-cycle pulse on filtered SCL falling edge.
- start_det_o  out  1  START pulse.
- rep_start_det_o  out  1  repeated-START pulse.
- stop_det_o  out  1  STOP pulse.
- bus_busy_o  out  1  bus-busy level.
- bit_cnt_o  out  4  SCL rises since the last START/rep-START (0..9).
- arb_lost_o  out  1  sticky arbitration-lost flag.
- scl_stretch_o  out  1  slave clock-stretch level.
REQ-003 Design SHALL use one clock, i2c_core_clock_i; reset_bit_i SHALL be synchronous and active-high.

Function
REQ-004 Each raw line SHALL pass through a SYNC_STAGES flop synchroniser, then a filter; the filtered output SHALL change only after the synchronised value differs from it for FILTER_LEN consecutive cycles.
REQ-005 A raw line change held long enough SHALL reach scl_o/sda_o exactly SYNC_STAGES+FILTER_LEN cycles later.
REQ-006 A raw pulse shorter than FILTER_LEN cycles SHALL produce no change on scl_o/sda_o.
REQ-007 scl_rise_o/scl_fall_o SHALL assert in the same cycle scl_o changes, for exactly one cycle.
REQ-008 START condition: sda_o falls while scl_o is high in both the previous and current cycle; STOP condition: sda_o rises under the same SCL condition.
REQ-009 If sda_o and scl_o change in the same cycle, the monitor SHALL report neither START nor STOP.
REQ-010 Bus FSM states SHALL be IDLE and BUSY, with transitions:
- IDLE->BUSY on START; start_det_o pulses.
- BUSY, START: rep_start_det_o pulses; start_det_o stays low; state stays BUSY.
- BUSY->IDLE on STOP; stop_det_o pulses.
- STOP in IDLE: stop_det_o pulses; state stays IDLE.
REQ-011 bus_busy_o SHALL be 1 exactly when the FSM is BUSY.
REQ-012 bit_cnt_o SHALL behave as follows:
- Clears to 0 on START, rep-START and STOP.
- Increments on scl_rise_o while BUSY.
- After 9, the next rise yields 1.
- Holds at 0 in IDLE.
REQ-013 scl_stretch_o SHALL be 1 while the master releases SCL high (master_scl_oe_i=0 or master_scl_i=1) and scl_o=0 for >=STRETCH_MIN consecutive cycles; it SHALL drop the cycle either condition ends; its counter saturates.

Reset
REQ-014 While reset_bit_i=1 at a clock edge, the following SHALL be true the next cycle:
- Synchroniser and filter state all 1s.
- scl_o=sda_o=1.
- All pulses 0.
- bus_busy_o=0, bit_cnt_o=0, arb_lost_o=0, scl_stretch_o=0.
- FSM in IDLE.
REQ-015 Reset asserted mid-transfer SHALL abort tracking; after release, the first START SHALL be reported as start_det_o, not rep_start_det_o.

Configuration
REQ-016 Macro I2C_BUS_MONITOR_ARB_LOST_EN, defined:
- arb_lost_o sets on a scl_rise_o cycle where master_sda_oe_i=1, master_sda_i=1, sda_o=0.
- Once set, it holds until arb_clr_i=1.
- If set and clear occur in the same cycle, set wins.
REQ-017 Macro I2C_BUS_MONITOR_ARB_LOST_EN, undefined: arb_lost_o SHALL be tied 0 and no detection logic synthesised; arb_clr_i is ignored.

Structure
REQ-018 Package i2c_pkg SHALL hold the bus-state enum (IDLE, BUSY) and the default constants for SYNC_STAGES, FILTER_LEN and STRETCH_MIN.
REQ-019 Sub-module i2c_glitch_filter (synchroniser plus filter, one line) SHALL be instantiated twice, for SCL and SDA.

Verification
REQ-020 Directed scenarios:
- Raw SDA 1->0 with SCL=1, defaults: start_det_o pulses 6 cycles later; bus_busy_o=1.
- 3-cycle SDA low glitch, FILTER_LEN=4: sda_o stays 1; no start/stop pulse.
- START, 9 SCL pulses, START, STOP: bit_cnt_o reaches 9; rep_start_det_o pulses once; bit_cnt_o=0 and bus_busy_o=0 after STOP.
- Macro defined, master drives SDA=1, bus SDA=0 at SCL rise: arb_lost_o=1 until arb_clr_i; arb_clr_i together with a new loss keeps it 1.
- master_scl_i=1, scl_i held 0 for 20 cycles: scl_stretch_o rises after 8 filtered-low cycles and falls when scl_o returns to 1.
- reset_bit_i during BUSY, then START: start_det_o (not rep_start_det_o) pulses.

Source files
------------

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared bus-state encoding and default tuning constants for
//               the I2C bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    localparam int unsigned c_SYNC_STAGES = 2;
    localparam int unsigned c_FILTER_LEN  = 4;
    localparam int unsigned c_STRETCH_MIN = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_glitch_filter.sv
// ============================================================================
// Module      : i2c_glitch_filter
// Description : Flop synchroniser plus persistence filter for one bus line,
//               with registered edge pulses and their next-cycle look-ahead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = c_SYNC_STAGES,
    parameter int unsigned FILTER_LEN  = c_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_rise_nxt,
    output logic o_fall_nxt
);

    localparam logic [3:0] c_LAST = 4'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic [3:0]             r_cnt;

    logic w_sync;
    logic w_diff;
    logic w_hit;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_diff = (w_sync != r_level);
    // Accept the new level on the FILTER_LEN-th consecutive differing cycle.
    assign w_hit  = w_diff && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '1;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_rise <= w_hit & w_sync;
            r_fall <= w_hit & ~w_sync;
            if (w_hit) begin
                r_level <= w_sync;
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level    = r_level;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_rise_nxt = w_hit & w_sync;
    assign o_fall_nxt = w_hit & ~w_sync;

endmodule

`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
// ============================================================================
// Module      : i2c_bus_monitor
// Description : Filters SCL/SDA, detects START/repeated-START/STOP, tracks bus
//               busy state, bit count, slave clock stretch and (optionally,
//               macro I2C_BUS_MONITOR_ARB_LOST_EN) arbitration loss.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = c_SYNC_STAGES,
    parameter int unsigned FILTER_LEN  = c_FILTER_LEN,
    parameter int unsigned STRETCH_MIN = c_STRETCH_MIN
) (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic       scl_i,
    input  logic       sda_i,
    input  logic       master_scl_oe_i,
    input  logic       master_scl_i,
    input  logic       master_sda_oe_i,
    input  logic       master_sda_i,
    input  logic       arb_clr_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic       scl_rise_o,
    output logic       scl_fall_o,
    output logic       start_det_o,
    output logic       rep_start_det_o,
    output logic       stop_det_o,
    output logic       bus_busy_o,
    output logic [3:0] bit_cnt_o,
    output logic       arb_lost_o,
    output logic       scl_stretch_o
);

    localparam logic [7:0] c_STRETCH_SAT = 8'(STRETCH_MIN);
    localparam logic [3:0] c_BIT_WRAP    = 4'd9;

    logic w_scl_level, w_scl_rise, w_scl_fall, w_scl_rise_nxt, w_scl_fall_nxt;
    logic w_sda_level, w_sda_rise, w_sda_fall, w_sda_rise_nxt, w_sda_fall_nxt;

    i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk        (i2c_core_clock_i),
        .rst        (reset_bit_i),
        .i_raw      (scl_i),
        .o_level    (w_scl_level),
        .o_rise     (w_scl_rise),
        .o_fall     (w_scl_fall),
        .o_rise_nxt (w_scl_rise_nxt),
        .o_fall_nxt (w_scl_fall_nxt)
    );

    i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk        (i2c_core_clock_i),
        .rst        (reset_bit_i),
        .i_raw      (sda_i),
        .o_level    (w_sda_level),
        .o_rise     (w_sda_rise),
        .o_fall     (w_sda_fall),
        .o_rise_nxt (w_sda_rise_nxt),
        .o_fall_nxt (w_sda_fall_nxt)
    );

    // Conditions are evaluated against the filtered values that appear at this
    // edge, so the detection pulses line up with the sda_o transition.
    logic w_scl_held_high;
    logic w_start;
    logic w_stop;
    logic w_sda_edge_unused;

    assign w_scl_held_high   = w_scl_level & ~w_scl_fall_nxt & ~w_scl_rise_nxt;
    assign w_start           = w_sda_fall_nxt & w_scl_held_high;
    assign w_stop            = w_sda_rise_nxt & w_scl_held_high;
    assign w_sda_edge_unused = &{1'b0, w_sda_rise, w_sda_fall};

    bus_state_t r_state;
    logic       r_start;
    logic       r_rep_start;
    logic       r_stop;
    logic [3:0] r_bit_cnt;

    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            r_state     <= IDLE;
            r_start     <= 1'b0;
            r_rep_start <= 1'b0;
            r_stop      <= 1'b0;
            r_bit_cnt   <= '0;
        end else begin
            r_start     <= 1'b0;
            r_rep_start <= 1'b0;
            r_stop      <= 1'b0;
            if (w_start) begin
                r_start     <= (r_state == IDLE);
                r_rep_start <= (r_state == BUSY);
                r_state     <= BUSY;
                r_bit_cnt   <= '0;
            end else if (w_stop) begin
                r_stop    <= 1'b1;
                r_state   <= IDLE;
                r_bit_cnt <= '0;
            end else if (w_scl_rise_nxt && (r_state == BUSY)) begin
                r_bit_cnt <= (r_bit_cnt == c_BIT_WRAP) ? 4'd1 : r_bit_cnt + 4'd1;
            end
        end
    end

    // Stretch: master has released SCL yet the bus keeps it low.
    logic       w_stretch_cond;
    logic [7:0] r_stretch_cnt;

    assign w_stretch_cond = (~master_scl_oe_i | master_scl_i) & ~w_scl_level;

    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i || !w_stretch_cond) begin
            r_stretch_cnt <= '0;
        end else if (r_stretch_cnt != c_STRETCH_SAT) begin
            r_stretch_cnt <= r_stretch_cnt + 8'd1;
        end
    end

`ifdef I2C_BUS_MONITOR_ARB_LOST_EN
    logic r_arb_lost;

    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            r_arb_lost <= 1'b0;
        end else if (w_scl_rise && master_sda_oe_i && master_sda_i && !w_sda_level) begin
            r_arb_lost <= 1'b1;
        end else if (arb_clr_i) begin
            r_arb_lost <= 1'b0;
        end
    end

    assign arb_lost_o = r_arb_lost;
`else
    logic w_arb_unused;

    assign w_arb_unused = &{1'b0, arb_clr_i, master_sda_oe_i, master_sda_i};
    assign arb_lost_o   = 1'b0;
`endif

    assign scl_o           = w_scl_level;
    assign sda_o           = w_sda_level;
    assign scl_rise_o      = w_scl_rise;
    assign scl_fall_o      = w_scl_fall;
    assign start_det_o     = r_start;
    assign rep_start_det_o = r_rep_start;
    assign stop_det_o      = r_stop;
    assign bus_busy_o      = (r_state == BUSY);
    assign bit_cnt_o       = r_bit_cnt;
    assign scl_stretch_o   = w_stretch_cond & (r_stretch_cnt == c_STRETCH_SAT);

endmodule

`default_nettype wire

// File: tb/tb_i2c_bus_monitor.sv
// ============================================================================
// Module      : tb_i2c_bus_monitor
// Description : Self-checking bench for i2c_bus_monitor; bus events are
//               scoreboarded, levels and latencies are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_bus_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl, sda;
    logic       m_scl_oe, m_scl, m_sda_oe, m_sda, arb_clr;
    logic       scl_o, sda_o, scl_rise_o, scl_fall_o;
    logic       start_det_o, rep_start_det_o, stop_det_o, bus_busy_o;
    logic [3:0] bit_cnt_o;
    logic       arb_lost_o, scl_stretch_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    bit m_busy   = 1'b0;
    int mon_code;
    int mon_exp;

    always #5 clk = ~clk;

    i2c_bus_monitor dut (
        .i2c_core_clock_i (clk),
        .reset_bit_i      (rst),
        .scl_i            (scl),
        .sda_i            (sda),
        .master_scl_oe_i  (m_scl_oe),
        .master_scl_i     (m_scl),
        .master_sda_oe_i  (m_sda_oe),
        .master_sda_i     (m_sda),
        .arb_clr_i        (arb_clr),
        .scl_o            (scl_o),
        .sda_o            (sda_o),
        .scl_rise_o       (scl_rise_o),
        .scl_fall_o       (scl_fall_o),
        .start_det_o      (start_det_o),
        .rep_start_det_o  (rep_start_det_o),
        .stop_det_o       (stop_det_o),
        .bus_busy_o       (bus_busy_o),
        .bit_cnt_o        (bit_cnt_o),
        .arb_lost_o       (arb_lost_o),
        .scl_stretch_o    (scl_stretch_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Event codes: 1 = START, 2 = repeated START, 3 = STOP.
    task automatic start_cond();
        exp_q.push_back(m_busy ? 2 : 1);
        m_busy = 1'b1;
        sda = 1'b0;
        tick(12);
    endtask

    task automatic stop_cond();
        exp_q.push_back(3);
        m_busy = 1'b0;
        sda = 1'b1;
        tick(12);
    endtask

    task automatic scl_pulse(input logic b);
        scl = 1'b0;
        tick(6);
        check("scl_fall_pulse", scl_fall_o, 1);
        tick(4);
        sda = b;
        tick(10);
        scl = 1'b1;
        tick(5);
        check("scl_rise_early", scl_rise_o, 0);
        tick(1);
        check("scl_rise_pulse", scl_rise_o, 1);
        tick(1);
        check("scl_rise_width", scl_rise_o, 0);
        tick(8);
    endtask

    always @(negedge clk) begin
        if (start_det_o || rep_start_det_o || stop_det_o) begin
            mon_code = start_det_o ? 1 : (rep_start_det_o ? 2 : 3);
            if (exp_q.size() == 0) begin
                check("unexpected_event", mon_code, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event_kind", mon_code, mon_exp);
                check("busy_at_event", bus_busy_o, (mon_exp == 3) ? 0 : 1);
            end
        end
    end

    initial begin
        rst = 1'b1; scl = 1'b1; sda = 1'b1;
        m_scl_oe = 1'b0; m_scl = 1'b0; m_sda_oe = 1'b0; m_sda = 1'b0; arb_clr = 1'b0;
        tick(3);
        check("rst_scl", scl_o, 1);
        check("rst_sda", sda_o, 1);
        check("rst_pulses", {scl_rise_o, scl_fall_o, start_det_o, rep_start_det_o, stop_det_o}, 0);
        check("rst_busy", bus_busy_o, 0);
        check("rst_bit_cnt", bit_cnt_o, 0);
        check("rst_arb", arb_lost_o, 0);
        check("rst_stretch", scl_stretch_o, 0);
        rst = 1'b0;
        tick(12);

        // START latency: sda_o and start_det_o follow 6 cycles after the raw change
        exp_q.push_back(1);
        m_busy = 1'b1;
        sda = 1'b0;
        tick(5);
        check("start_early", start_det_o, 0);
        check("sda_early", sda_o, 1);
        tick(1);
        check("start_latency", start_det_o, 1);
        check("sda_latency", sda_o, 0);
        check("busy_after_start", bus_busy_o, 1);
        tick(1);
        check("start_width", start_det_o, 0);
        tick(5);

        // Ten bits: count runs 1..9 then wraps to 1
        for (int i = 1; i <= 10; i++) begin
            scl_pulse(1'b0);
            check("bit_cnt", bit_cnt_o, (i == 10) ? 1 : i);
        end
        scl_pulse(1'b1);
        check("bit_cnt_11", bit_cnt_o, 2);
        start_cond();
        check("bit_cnt_rep", bit_cnt_o, 0);
        check("busy_rep", bus_busy_o, 1);
        scl_pulse(1'b0);
        stop_cond();
        check("bit_cnt_stop", bit_cnt_o, 0);
        check("busy_stop", bus_busy_o, 0);

        // STOP while idle: pulse reported, state stays idle, rises not counted
        scl = 1'b0; tick(12);
        sda = 1'b0; tick(12);
        scl = 1'b1; tick(12);
        check("idle_bit_cnt", bit_cnt_o, 0);
        stop_cond();
        check("idle_stop_busy", bus_busy_o, 0);

        // 3-cycle SDA glitch must not reach sda_o
        sda = 1'b0;
        tick(3);
        sda = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_sda", sda_o, 1);
        end

        // Simultaneous SCL/SDA change: neither START nor STOP
        scl = 1'b0; sda = 1'b0;
        tick(12);
        check("simul_scl", scl_o, 0);
        check("simul_sda", sda_o, 0);
        check("simul_busy", bus_busy_o, 0);
        sda = 1'b1; tick(12);
        scl = 1'b1; tick(12);

        // Arbitration loss
        start_cond();
        m_sda_oe = 1'b1; m_sda = 1'b1;
        scl_pulse(1'b0);
`ifdef I2C_BUS_MONITOR_ARB_LOST_EN
        check("arb_set", arb_lost_o, 1);
        m_sda_oe = 1'b0;
        tick(3);
        check("arb_hold", arb_lost_o, 1);
        arb_clr = 1'b1;
        tick(1);
        check("arb_clear", arb_lost_o, 0);
        m_sda_oe = 1'b1;
        scl = 1'b0;
        tick(10);
        scl = 1'b1;
        tick(7);
        check("arb_set_wins", arb_lost_o, 1);
        arb_clr = 1'b0;
        tick(1);
        check("arb_after_both", arb_lost_o, 1);
        tick(7);
`else
        check("arb_disabled", arb_lost_o, 0);
        arb_clr = 1'b1;
        tick(2);
        check("arb_disabled_clr", arb_lost_o, 0);
`endif
        arb_clr = 1'b0; m_sda_oe = 1'b0; m_sda = 1'b0;
        scl_pulse(1'b0);
        stop_cond();

        // Clock stretch: master releases SCL, bus holds it low for 20 cycles
        m_scl_oe = 1'b1; m_scl = 1'b1;
        scl = 1'b0;
        tick(13);
        check("stretch_early", scl_stretch_o, 0);
        tick(1);
        check("stretch_on", scl_stretch_o, 1);
        tick(6);
        scl = 1'b1;
        tick(5);
        check("stretch_hold", scl_stretch_o, 1);
        tick(1);
        check("stretch_off", scl_stretch_o, 0);
        check("stretch_scl_back", scl_o, 1);
        m_scl = 1'b0;
        scl = 1'b0;
        tick(20);
        check("stretch_master_low", scl_stretch_o, 0);
        scl = 1'b1;
        tick(12);
        m_scl_oe = 1'b0;

        // Reset mid-transfer, then the next START is a plain START
        start_cond();
        for (int i = 0; i < 3; i++) scl_pulse(1'b0);
        check("pre_reset_cnt", bit_cnt_o, 3);
        scl = 1'b0;
        rst = 1'b1;
        m_busy = 1'b0;
        tick(2);
        check("mid_rst_busy", bus_busy_o, 0);
        check("mid_rst_cnt", bit_cnt_o, 0);
        check("mid_rst_sda", sda_o, 1);
        rst = 1'b0;
        tick(12);
        check("post_rst_busy", bus_busy_o, 0);
        sda = 1'b1; tick(12);
        scl = 1'b1; tick(12);
        start_cond();
        check("post_rst_start_busy", bus_busy_o, 1);
        scl_pulse(1'b0);
        stop_cond();

        tick(5);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
